// File: rtl/datapath_pkg.sv
// Shared op codes, FSM state encoding and default sizing for datapath_pipe.
package datapath_pkg;

  localparam int DW_DEF   = 16;
  localparam int NREG_DEF = 8;
  localparam int AW_DEF   = 8;
  localparam int PCW_DEF  = 16;

  typedef enum logic [2:0] {
    OP_ADDSUB = 3'd0,
    OP_LHI    = 3'd1,
    OP_LLI    = 3'd2,
    OP_LD     = 3'd3,
    OP_ST     = 3'd4,
    OP_JMP    = 3'd5,
    OP_BZ     = 3'd6,
    OP_OUT    = 3'd7
  } op_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_MEM  = 2'd2;
  localparam state_t ST_WB   = 2'd3;

endpackage

// File: rtl/dp_regfile.sv
// NREG x DW register file: two asynchronous read ports, one synchronous write port.
module dp_regfile
  import datapath_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] ra_addr,
  input  logic [RW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [RW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] regs [NREG];

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

  // register array with async clear and single write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= {DW{1'b0}};
      end
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

endmodule

// File: rtl/datapath_pipe.sv
// Multi-cycle micro-op datapath: one op in flight, IDLE/EXEC/MEM/WB sequencing.
// Optional macro DATAPATH_SAT_EN makes ADDSUB saturate on signed overflow.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int PCW  = PCW_DEF,
  localparam int RW  = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [2:0]     op_code,
  input  logic [RW-1:0]  op_rd,
  input  logic [RW-1:0]  op_ra,
  input  logic [RW-1:0]  op_rb,
  input  logic [DW-1:0]  op_imm,
  input  logic           op_use_imm,
  input  logic           op_sub,
  output logic [PCW-1:0] pc,
  output logic           n,
  output logic           z,
  output logic           v,
  output logic           c,
  output logic [DW-1:0]  out_r,
  output logic           busy
);

  state_t        state, state_nx;
  op_t           op_q;
  logic [RW-1:0] rd_q, ra_q, rb_q;
  logic [DW-1:0] imm_q;
  logic          use_imm_q, sub_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] mem [2**AW];

  logic [RW-1:0] rf_ra_addr;
  logic [DW-1:0] rf_ra_data, rf_rb_data;
  logic          rf_we;
  logic [DW-1:0] rf_wd;

  logic [DW-1:0]  b_val, b_op, alu_res;
  logic [DW:0]    sum_ext;
  logic           alu_ovf;
  logic [AW-1:0]  eff_addr;
  logic [PCW-1:0] pc_inc;

  dp_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (rf_ra_addr),
    .rb_addr (rb_q),
    .ra_data (rf_ra_data),
    .rb_data (rf_rb_data),
    .we      (rf_we),
    .wa      (rd_q),
    .wd      (rf_wd)
  );

  // ALU, address generation and next-state decode
  always_comb begin
    b_val   = use_imm_q ? imm_q : rf_rb_data;
    b_op    = sub_q ? ~b_val : b_val;
    // subtract as a + ~b + 1 so the carry out is directly NOT borrow
    sum_ext = {1'b0, rf_ra_data} + {1'b0, b_op} + {{DW{1'b0}}, sub_q};
    alu_ovf = (rf_ra_data[DW-1] == b_op[DW-1]) && (sum_ext[DW-1] != rf_ra_data[DW-1]);
`ifdef DATAPATH_SAT_EN
    if (alu_ovf) begin
      alu_res = rf_ra_data[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      alu_res = sum_ext[DW-1:0];
    end
`else
    alu_res = sum_ext[DW-1:0];
`endif
    eff_addr   = rf_ra_data[AW-1:0] + imm_q[AW-1:0];
    pc_inc     = pc + {{(PCW-1){1'b0}}, 1'b1};
    // LHI needs the old destination value to keep its low half
    rf_ra_addr = (op_q == OP_LHI) ? rd_q : ra_q;

    case (state)
      ST_IDLE: state_nx = op_valid ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_nx = (op_q == OP_LD) ? ST_MEM : ST_IDLE;
      ST_MEM:  state_nx = ST_WB;
      ST_WB:   state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // register-file write selection
  always_comb begin
    rf_we = 1'b0;
    rf_wd = {DW{1'b0}};
    case (state)
      ST_EXEC: begin
        case (op_q)
          OP_ADDSUB: begin rf_we = 1'b1; rf_wd = alu_res; end
          OP_LHI:    begin rf_we = 1'b1; rf_wd = {imm_q[DW/2-1:0], rf_ra_data[DW/2-1:0]}; end
          OP_LLI:    begin rf_we = 1'b1; rf_wd = {{(DW/2){imm_q[DW/2-1]}}, imm_q[DW/2-1:0]}; end
          OP_JMP:    begin rf_we = 1'b1; rf_wd = DW'(pc_inc); end
          default:   begin rf_we = 1'b0; rf_wd = {DW{1'b0}}; end
        endcase
      end
      ST_WB:   begin rf_we = 1'b1; rf_wd = mem_q; end
      default: begin rf_we = 1'b0; rf_wd = {DW{1'b0}}; end
    endcase
  end

  // FSM, captured op fields, pc, flags and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_ready  <= 1'b1;
      busy      <= 1'b0;
      op_q      <= OP_ADDSUB;
      rd_q      <= {RW{1'b0}};
      ra_q      <= {RW{1'b0}};
      rb_q      <= {RW{1'b0}};
      imm_q     <= {DW{1'b0}};
      use_imm_q <= 1'b0;
      sub_q     <= 1'b0;
      addr_q    <= {AW{1'b0}};
      mem_q     <= {DW{1'b0}};
      pc        <= {PCW{1'b0}};
      {n, z, v, c} <= 4'b0000;
      out_r     <= {DW{1'b0}};
    end else begin
      state    <= state_nx;
      op_ready <= (state_nx == ST_IDLE);
      busy     <= (state_nx != ST_IDLE);
      if (state == ST_IDLE && op_valid) begin
        op_q      <= op_t'(op_code);
        rd_q      <= op_rd;
        ra_q      <= op_ra;
        rb_q      <= op_rb;
        imm_q     <= op_imm;
        use_imm_q <= op_use_imm;
        sub_q     <= op_sub;
      end
      case (state)
        ST_EXEC: begin
          addr_q <= eff_addr;
          case (op_q)
            OP_ADDSUB: begin
              n  <= alu_res[DW-1];
              z  <= (alu_res == {DW{1'b0}});
              v  <= alu_ovf;
              c  <= sum_ext[DW];
              pc <= pc_inc;
            end
            OP_JMP:  pc <= imm_q[PCW-1:0];
            OP_BZ:   pc <= z ? (pc + imm_q[PCW-1:0]) : pc_inc;
            OP_OUT:  begin out_r <= rf_ra_data; pc <= pc_inc; end
            OP_LD:   pc <= pc;
            default: pc <= pc_inc;
          endcase
        end
        ST_MEM:  mem_q <= mem[addr_q];
        ST_WB:   pc <= pc_inc;
        default: pc <= pc;
      endcase
    end
  end

  // data memory write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (state == ST_EXEC && op_q == OP_ST) begin
      mem[eff_addr] <= rf_rb_data;
    end
  end

endmodule
